pipelined_processor_enc_stream: RTL and testbench

- Streaming 3-round encryptor. It is the forward direction of the team's 3-stage pipelined decryptor, so its output blocks are that decryptor's input blocks.
- Accepts one 32-bit word (4 bytes) per beat over valid/ready and pushes each word through three registered rounds.
- Rounds are keyed by k9k8, then k7k6, then k5k4.
- Reassembles four ciphertext words into one 128-bit block with a valid/ready output handshake.
- Sits between the plaintext source and the block sink of the crypto accelerator.

---
 rtl/enc_pkg.sv | 20 ++
 rtl/enc_round.sv | 35 +++
 rtl/pipelined_processor_enc_stream.sv | 115 +++++++++++
 tb/tb_pipelined_processor_enc_stream.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the streaming 3-round encryptor.
//   BYTE_W / WORD_W / NWORDS : datapath geometry (4 bytes per word, 4 words per block)
//   kb_of(kk)                : expands a 2-bit round key into the 8-bit whitening byte
//   rotl8(b)                 : rotate a byte left by one bit
package enc_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int NWORDS = 4;

    // Whitening byte {kk, ~kk, kk, ~kk}; e.g. kk=00 -> 8'h33, kk=11 -> 8'hCC.
    function automatic logic [BYTE_W-1:0] kb_of(input logic [1:0] kk);
        return {kk, ~kk, kk, ~kk};
    endfunction

    function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], b[BYTE_W-1]};
    endfunction

endpackage

// File: rtl/enc_round.sv
// One combinational encryption round.
//   x  [31:0] : input word, byte0 = [31:24] ... byte3 = [7:0]
//   kk [1:0]  : round key pair
//   y  [31:0] : output word
// Each byte is XORed with the whitening byte and rotated left by one; when
// kk[0] is set the bytes are additionally rotated one position toward byte0.
module enc_round
    import enc_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [1:0]        kk,
    output logic [WORD_W-1:0] y
);

    logic [BYTE_W-1:0] kb_s;
    logic [BYTE_W-1:0] t0_s;
    logic [BYTE_W-1:0] t1_s;
    logic [BYTE_W-1:0] t2_s;
    logic [BYTE_W-1:0] t3_s;

    // Byte whitening, bit rotation and optional byte permutation.
    always_comb begin
        kb_s = kb_of(kk);
        t0_s = rotl8(x[31:24] ^ kb_s);
        t1_s = rotl8(x[23:16] ^ kb_s);
        t2_s = rotl8(x[15:8]  ^ kb_s);
        t3_s = rotl8(x[7:0]   ^ kb_s);
        if (kk[0]) begin
            y = {t1_s, t2_s, t3_s, t0_s};
        end else begin
            y = {t0_s, t1_s, t2_s, t3_s};
        end
    end

endmodule

// File: rtl/pipelined_processor_enc_stream.sv
// Streaming 3-round encryptor: words enter over valid/ready, pass through three
// registered rounds (keys k9k8, k7k6, k5k4) and are packed four at a time into a
// 128-bit block presented over a valid/ready output handshake.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   Enable     : global advance; low freezes every register
//   key[9:4]   : round keys, captured together with each accepted word
//   in_valid / in_ready / in_word[31:0]     : plaintext word input
//   out_valid / out_ready / block[127:0]    : ciphertext block output, word0 = [127:96]
module pipelined_processor_enc_stream
    import enc_pkg::*;
#(
    parameter int NWORDS = enc_pkg::NWORDS
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Enable,
    input  logic [9:4]               key,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] block
);

    localparam int CNT_W = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    logic                     s1_valid_r;
    logic                     s2_valid_r;
    logic                     s3_valid_r;
    logic [WORD_W-1:0]        s1_data_r;
    logic [WORD_W-1:0]        s2_data_r;
    logic [WORD_W-1:0]        s3_data_r;
    logic [3:0]               s1_key_r;   // key[7:4] riding with the word in S1
    logic [1:0]               s2_key_r;   // key[5:4] riding with the word in S2
    logic [CNT_W-1:0]         cnt_r;
    logic                     out_valid_r;
    logic [WORD_W*NWORDS-1:0] block_r;

    logic [WORD_W-1:0]        r1_y_s;
    logic [WORD_W-1:0]        r2_y_s;
    logic [WORD_W-1:0]        r3_y_s;
    logic                     stall_s;
    logic                     adv_s;
    logic                     wr_s;
    logic                     last_s;

    enc_round u_round1 (.x(in_word),   .kk(key[9:8]),       .y(r1_y_s));
    enc_round u_round2 (.x(s1_data_r), .kk(s1_key_r[3:2]),  .y(r2_y_s));
    enc_round u_round3 (.x(s2_data_r), .kk(s2_key_r),       .y(r3_y_s));

    // Stall only when a finished block is unread and S3 has a word waiting to
    // overwrite it; bubbles in S3 never block the pipeline.
    always_comb begin
        stall_s = out_valid_r & ~out_ready & s3_valid_r;
        adv_s   = Enable & ~stall_s;
        wr_s    = adv_s & s3_valid_r;
        last_s  = wr_s & (cnt_r == LAST_CNT);
    end

    // Gated by reset so the source sees no ready while the block is held in reset.
    assign in_ready  = adv_s & reset;
    assign out_valid = out_valid_r;
    assign block     = block_r;

    // Three round registers; the key slices needed downstream travel with each word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
            s1_data_r  <= {WORD_W{1'b0}};
            s2_data_r  <= {WORD_W{1'b0}};
            s3_data_r  <= {WORD_W{1'b0}};
            s1_key_r   <= 4'b0000;
            s2_key_r   <= 2'b00;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            s1_data_r  <= r1_y_s;
            s1_key_r   <= key[7:4];
            s2_valid_r <= s1_valid_r;
            s2_data_r  <= r2_y_s;
            s2_key_r   <= s1_key_r[1:0];
            s3_valid_r <= s2_valid_r;
            s3_data_r  <= r3_y_s;
        end
    end

    // Block assembler: drops S3 words into successive slots and raises out_valid
    // on the last one; that raise wins over a same-edge handshake clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            block_r     <= {(WORD_W*NWORDS){1'b0}};
        end else begin
            if (wr_s) begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (cnt_r == CNT_W'(w)) begin
                        block_r[WORD_W*(NWORDS-1-w) +: WORD_W] <= s3_data_r;
                    end
                end
                cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            end
            if (last_s) begin
                out_valid_r <= 1'b1;
            end else if (Enable & out_valid_r & out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_processor_enc_stream.sv
// Directed bench for pipelined_processor_enc_stream. Expected ciphertext is
// hand-derived: with key=000000 every byte maps to rotl3(b) ^ 8'h33
// (00->33, 01->3B, 02->23, 03->2B, 04->13, 05->1B, 06->03, 07->0B, 08->73);
// with key=111111 the word 01020304 maps to ECC4DCD4.
module tb_pipelined_processor_enc_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         Enable;
    logic [9:4]   key;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] block;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] BLK_ZERO = {4{32'h33333333}};
    localparam logic [127:0] BLK_PERM = {4{32'hECC4DCD4}};
    localparam logic [127:0] BLK_1234 = {32'h3B3B3B3B, 32'h23232323, 32'h2B2B2B2B, 32'h13131313};
    localparam logic [127:0] BLK_5678 = {32'h1B1B1B1B, 32'h03030303, 32'h0B0B0B0B, 32'h73737373};

    always #5 clk = ~clk;

    pipelined_processor_enc_stream dut (
        .clk       (clk),
        .reset     (reset),
        .Enable    (Enable),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .block     (block)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word, confirm it will be accepted, and clock it in.
    task automatic beat(input logic [31:0] w, input logic [5:0] k);
        in_valid = 1'b1;
        in_word  = w;
        key      = k;
        #1;
        chk("beat_in_ready", 128'(in_ready), 128'd1);
        tick();
    endtask

    function automatic logic [31:0] rep(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {4{b}};
    endfunction

    initial begin
        reset     = 1'b0;
        Enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key       = 6'b000000;
        in_word   = 32'h00000000;
        #2;
        chk("rst_in_ready",  128'(in_ready),  128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_block",     block,           128'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic: four zero words, key 000000.
        for (int i = 0; i < 4; i++) beat(32'h00000000, 6'b000000);
        in_valid = 1'b0;
        tick();
        tick();
        chk("basic_valid_e5", 128'(out_valid), 128'd0);
        tick();
        chk("basic_valid_e6", 128'(out_valid), 128'd1);
        chk("basic_block",    block,           BLK_ZERO);
        tick();
        chk("basic_valid_e7", 128'(out_valid), 128'd0);
        chk("basic_hold",     block,           BLK_ZERO);

        // Permutation path: key 111111.
        for (int i = 0; i < 4; i++) beat(32'h01020304, 6'b111111);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("perm_valid", 128'(out_valid), 128'd1);
        chk("perm_block", block,           BLK_PERM);
        tick();
        chk("perm_clear", 128'(out_valid), 128'd0);

        // Backpressure: 8 distinct words with the sink stalled.
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) beat(rep(i), 6'b000000);
        chk("bp_valid",   128'(out_valid), 128'd1);
        chk("bp_block1",  block,           BLK_1234);
        in_valid = 1'b1;
        in_word  = rep(8);
        #1;
        chk("bp_in_ready_low", 128'(in_ready), 128'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_block", block,           BLK_1234);
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_ready", 128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_handshake", 128'(out_valid),  128'd0);
        chk("bp_word0",     128'(block[127:96]), 128'h1B1B1B1B);
        tick();
        tick();
        chk("bp_valid_f2", 128'(out_valid), 128'd0);
        tick();
        chk("bp_valid_f3", 128'(out_valid), 128'd1);
        chk("bp_block2",   block,           BLK_5678);
        tick();
        chk("bp_clear", 128'(out_valid), 128'd0);

        // Key change between back-to-back blocks.
        for (int i = 0; i < 4; i++) beat(32'h00000000, 6'b000000);
        for (int i = 0; i < 3; i++) beat(32'h01020304, 6'b111111);
        chk("kc_valid_a", 128'(out_valid), 128'd1);
        chk("kc_block_a", block,           BLK_ZERO);
        beat(32'h01020304, 6'b111111);
        in_valid = 1'b0;
        chk("kc_valid_e7", 128'(out_valid), 128'd0);
        chk("kc_overlap",  block, {32'hECC4DCD4, {3{32'h33333333}}});
        tick();
        tick();
        chk("kc_valid_e9", 128'(out_valid), 128'd0);
        tick();
        chk("kc_valid_b", 128'(out_valid), 128'd1);
        chk("kc_block_b", block,           BLK_PERM);
        tick();

        // Enable freeze mid-block, then freeze with a pending block.
        beat(rep(1), 6'b000000);
        beat(rep(2), 6'b000000);
        Enable   = 1'b0;
        in_valid = 1'b1;
        in_word  = rep(3);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("frz_in_ready", 128'(in_ready), 128'd0);
            tick();
            chk("frz_valid", 128'(out_valid), 128'd0);
            chk("frz_block", block,           BLK_PERM);
        end
        Enable = 1'b1;
        beat(rep(3), 6'b000000);
        beat(rep(4), 6'b000000);
        in_valid = 1'b0;
        tick();
        tick();
        chk("frz_valid_g3", 128'(out_valid), 128'd0);
        tick();
        chk("frz_valid_g4", 128'(out_valid), 128'd1);
        chk("frz_result",   block,           BLK_1234);
        Enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("frz_no_handshake", 128'(out_valid), 128'd1);
        end
        Enable = 1'b1;
        tick();
        chk("frz_handshake", 128'(out_valid), 128'd0);

        // Reset mid-block discards partial and in-flight words.
        beat(rep(1), 6'b000000);
        beat(rep(2), 6'b000000);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mrst_valid",    128'(out_valid), 128'd0);
        chk("mrst_block",    block,           128'd0);
        chk("mrst_in_ready", 128'(in_ready),  128'd0);
        tick();
        reset = 1'b1;
        for (int i = 5; i <= 8; i++) beat(rep(i), 6'b000000);
        in_valid = 1'b0;
        tick();
        tick();
        chk("mrst_valid_e5", 128'(out_valid), 128'd0);
        tick();
        chk("mrst_valid_e6", 128'(out_valid), 128'd1);
        chk("mrst_block2",   block,           BLK_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
